// File: rtl/field_serializer_pkg.sv
// Shared types for the field serializer: field indices and FSM states.
package field_serializer_pkg;

    typedef enum logic [1:0] {
        FIELD_X = 2'd0,
        FIELD_Y = 2'd1,
        FIELD_Z = 2'd2
    } field_e;

    localparam int NUM_FIELDS = 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

endpackage

// File: rtl/field_ser_next_ch.sv
// Priority finder: next enabled channel strictly above idx,
// the lowest enabled channel, and a flag when nothing lies above idx.
module field_ser_next_ch
    import field_serializer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CW     = 1
) (
    input  logic [NUM_CH-1:0] mask,
    input  logic [CW-1:0]     idx,
    output logic [CW-1:0]     next_ch,
    output logic [CW-1:0]     first_ch,
    output logic              none
);

    always_comb begin
        next_ch  = '0;
        first_ch = '0;
        none     = 1'b1;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(idx))) begin
                next_ch = CW'(i);
                none    = 1'b0;
            end
            if (mask[i]) begin
                first_ch = CW'(i);
            end
        end
    end

endmodule

// File: rtl/field_serializer.sv
// Serializes NUM_CH x {x,y,z} records into one field per beat,
// skipping masked channels, in channel-major or field-major order.
module field_serializer
    import field_serializer_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int W      = 8,
    parameter int ORDER  = 0,
    localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_CH*NUM_FIELDS*W-1:0] in_data,
    input  logic [NUM_CH-1:0]          in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [CW-1:0]              out_ch,
    output logic [1:0]                 out_field,
    output logic                       out_last
);

    state_e                        state;
    logic [NUM_CH*NUM_FIELDS*W-1:0] data_q;
    logic [NUM_CH-1:0]             mask_q;
    logic [CW-1:0]                 ch_q;
    logic [CW-1:0]                 hi_q;
    logic [1:0]                    fld_q;
    logic                          valid_q;
    logic                          last_q;
    logic [W-1:0]                  dout_q;

    logic [CW-1:0] cur_next;
    logic [CW-1:0] cur_first;
    logic          cur_none;
    logic [CW-1:0] in_first;
    logic [CW-1:0] in_hi;
    logic          in_found;
    logic [CW-1:0] nc;
    logic [1:0]    nf;

    field_ser_next_ch #(
        .NUM_CH (NUM_CH),
        .CW     (CW)
    ) u_next (
        .mask     (mask_q),
        .idx      (ch_q),
        .next_ch  (cur_next),
        .first_ch (cur_first),
        .none     (cur_none)
    );

    // Lowest and highest enabled channel of the incoming set
    always_comb begin
        in_first = '0;
        in_hi    = '0;
        in_found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (in_mask[i]) begin
                if (!in_found) begin
                    in_first = CW'(i);
                end
                in_found = 1'b1;
                in_hi    = CW'(i);
            end
        end
    end

    generate
        if (ORDER == 0) begin : g_ch_major
            always_comb begin
                if (fld_q != FIELD_Z) begin
                    nc = ch_q;
                    nf = fld_q + 2'd1;
                end else begin
                    nc = cur_none ? cur_first : cur_next;
                    nf = FIELD_X;
                end
            end
        end else begin : g_field_major
            always_comb begin
                if (!cur_none) begin
                    nc = cur_next;
                    nf = fld_q;
                end else begin
                    nc = cur_first;
                    nf = fld_q + 2'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            data_q  <= '0;
            mask_q  <= '0;
            ch_q    <= '0;
            hi_q    <= '0;
            fld_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            dout_q  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        data_q <= in_data;
                        mask_q <= in_mask;
                        if (|in_mask) begin
                            state   <= S_SEND;
                            valid_q <= 1'b1;
                            ch_q    <= in_first;
                            hi_q    <= in_hi;
                            fld_q   <= FIELD_X;
                            last_q  <= 1'b0;
                            dout_q  <= in_data[int'(in_first)*NUM_FIELDS*W +: W];
                        end
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (last_q) begin
                            state   <= S_IDLE;
                            valid_q <= 1'b0;
                            ch_q    <= '0;
                            fld_q   <= '0;
                            last_q  <= 1'b0;
                            dout_q  <= '0;
                        end else begin
                            ch_q   <= nc;
                            fld_q  <= nf;
                            dout_q <= data_q[(int'(nc)*NUM_FIELDS + int'(nf))*W +: W];
                            last_q <= (nf == FIELD_Z) && (nc == hi_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Reset masks the outputs in the same cycle it is asserted
    assign in_ready  = (state == S_IDLE) && !rst;
    assign out_valid = valid_q && !rst;
    assign out_data  = out_valid ? dout_q : '0;
    assign out_ch    = out_valid ? ch_q : '0;
    assign out_field = out_valid ? fld_q : '0;
    assign out_last  = out_valid && last_q;

endmodule

// File: doc/field_serializer.md
FIELD_SERIALIZER -- requirements
Module: field_serializer

Interface
REQ-001 Parameter NUM_CH, default 2: number of channel records per input word; the block SHALL support NUM_CH of 1 to 16.
REQ-002 Parameter W, default 8: width of each field; the block SHALL support W of 1 to 64.
REQ-003 Parameter ORDER, default 0: beat ordering; 0 = channel-major, 1 = field-major.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  input record set offered.
REQ-007 in_ready  output  1  block can accept a record set.
REQ-008 in_data  input  NUM_CH*3*W  packed records; channel c, field f occupies bits [(c*3+f)*W +: W].
REQ-009 in_mask  input  NUM_CH  per-channel enable; a 0 bit suppresses all beats for that channel.
REQ-010 out_valid  output  1  beat present.
REQ-011 out_ready  input  1  downstream accepts beat.
REQ-012 out_data  output  W  field value.
REQ-013 out_ch  output  max(1,$clog2(NUM_CH))  channel index of beat.
REQ-014 out_field  output  2  field index: 0 = x, 1 = y, 2 = z.
REQ-015 out_last  output  1  final beat of the current record set.

Function
REQ-016 The block SHALL implement two states: IDLE and SEND.
REQ-017 in_ready SHALL be 1 in IDLE and 0 in SEND.
REQ-018 When in_valid && in_ready, the block SHALL register in_data and in_mask.
REQ-019 An accepted set with a nonzero mask SHALL move the block to SEND, with out_valid high in the next cycle (1-cycle latency).
REQ-020 An accepted set with an all-zero mask SHALL be consumed with no beats; the block SHALL stay in IDLE with in_ready held at 1.
REQ-021 ORDER=0 SHALL emit, for each enabled channel in ascending index, fields x, y, z in that order.
REQ-022 ORDER=1 SHALL emit field x for all enabled channels in ascending index, then field y for all, then field z for all.
REQ-023 Disabled channels SHALL be skipped with no bubble cycles; with out_ready held at 1, the block SHALL emit one beat per cycle.
REQ-024 A beat SHALL advance only on out_valid && out_ready.
REQ-025 While out_valid && !out_ready, out_data, out_ch, out_field and out_last SHALL hold stable.
REQ-026 out_last SHALL be 1 only on the final beat: channel = highest enabled index, field = z.
REQ-027 The handshake on the out_last beat SHALL return the block to IDLE, with in_ready = 1 in the following cycle; there is no same-cycle re-accept.
REQ-028 Total beats per set SHALL equal 3 x popcount(mask).
REQ-029 When out_valid is 0, out_data, out_ch, out_field and out_last SHALL be 0.

Reset
REQ-030 While rst is high, the block SHALL force state to IDLE, out_valid to 0, in_ready to 0, and all data registers to 0.
REQ-031 In the first cycle after rst deasserts, in_ready SHALL be 1.
REQ-032 Reset asserted in SEND SHALL abort the set immediately; no further beats of that set SHALL be emitted.

Structure
REQ-033 Package field_serializer_pkg SHALL hold the field enum (FIELD_X = 0, FIELD_Y = 1, FIELD_Z = 2), NUM_FIELDS = 3, and the state enum.
REQ-034 Sub-module field_ser_next_ch SHALL be a combinational priority finder that returns the next enabled channel strictly above a given index, the first enabled channel, and a "none" flag.
REQ-035 ORDER SHALL select the traversal at elaboration time; the block SHALL contain no runtime mode logic.

Verification
REQ-036 Scenario, NUM_CH=2, W=8, ORDER=0: mask=2'b11; ch0 = {x=0x10, y=0x11, z=0x12}, ch1 = {x=0x20, y=0x21, z=0x22}; out_ready=1 -> beats 10, 11, 12, 20, 21, 22 on consecutive cycles; out_last on 22 only; in_ready returns 1 in the cycle after 22.
REQ-037 Scenario, same data, ORDER=1 -> beats 10, 20, 11, 21, 12, 22; out_field sequence 0, 0, 1, 1, 2, 2.
REQ-038 Scenario, NUM_CH=4, mask=4'b1010 -> only ch1 and ch3 beats (6 total), no idle gaps, out_ch sequence 1, 1, 1, 3, 3, 3.
REQ-039 Scenario: mask=0 accepted -> no out_valid; in_ready stays 1; a second set accepted on the next cycle is serialized normally.
REQ-040 Scenario: out_ready toggled 1, 0, 0, 1 during SEND -> outputs hold while stalled; no beat lost or duplicated; order per REQ-021.
REQ-041 Scenario: rst pulsed for 1 cycle after the second beat -> out_valid = 0 in the reset cycle, in_ready = 1 in the next cycle, and no residual beats.
